// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
//
// Iterative multiply/divide engine that owns the architectural HI/LO pair.
// One result bit is produced per clock: shift-add for MULT/MULTU and
// restoring division for DIV/DIVU. A final fix-up cycle applies the sign
// correction for signed operations and commits the result to HI/LO.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        operation request, sampled only while idle
//   alu_opcode   11=MULT, 12=MULTU, 13=DIV, 14=DIVU (other codes ignored)
//   in_s1        multiplicand / dividend
//   in_s2        multiplier / divisor
//   hi_wr_en     MTHI write strobe (honoured only while idle)
//   lo_wr_en     MTLO write strobe (honoured only while idle)
//   wr_data      MTHI/MTLO data
//   busy         operation in progress
//   done         one-cycle pulse after HI/LO were updated by an operation
//   div_by_zero  sticky flag: last accepted operation was a divide by zero
//   hi, lo       HI and LO registers
// ---------------------------------------------------------------------------
module muldiv_unit #(
  parameter int data_width = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4:0]            alu_opcode,
  input  logic [data_width-1:0] in_s1,
  input  logic [data_width-1:0] in_s2,
  input  logic                  hi_wr_en,
  input  logic                  lo_wr_en,
  input  logic [data_width-1:0] wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  div_by_zero,
  output logic [data_width-1:0] hi,
  output logic [data_width-1:0] lo
);

  localparam int W  = data_width;
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  localparam logic [4:0] OP_MULT  = 5'd11;
  localparam logic [4:0] OP_MULTU = 5'd12;
  localparam logic [4:0] OP_DIV   = 5'd13;
  localparam logic [4:0] OP_DIVU  = 5'd14;

  logic [1:0]     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           is_div_q, is_div_d;
  logic           neg_quo_q, neg_quo_d;
  logic           neg_rem_q, neg_rem_d;
  logic           dbz_q, dbz_d;
  logic           done_q, done_d;
  logic [W-1:0]   a_q, a_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [W-1:0]   hi_q, hi_d;
  logic [W-1:0]   lo_q, lo_d;

  logic           op_valid, op_signed, op_div;
  logic           s1_neg, s2_neg;
  logic [W-1:0]   s1_abs, s2_abs;
  logic [W:0]     mul_sum;
  logic [W:0]     div_trial, div_diff;
  logic           div_ge;
  logic [W-1:0]   div_rem_nxt;
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quo_fix, rem_fix;

  // Operand decode and one iteration step of each algorithm.
  // For multiply, acc holds {partial product, remaining multiplier bits};
  // a_q holds the multiplicand. For divide, acc holds {remainder, dividend
  // bits shifted into the quotient}; a_q holds the divisor.
  always_comb begin
    op_valid  = (alu_opcode == OP_MULT) || (alu_opcode == OP_MULTU) ||
                (alu_opcode == OP_DIV)  || (alu_opcode == OP_DIVU);
    op_signed = (alu_opcode == OP_MULT) || (alu_opcode == OP_DIV);
    op_div    = (alu_opcode == OP_DIV)  || (alu_opcode == OP_DIVU);
    s1_neg    = op_signed && in_s1[W-1];
    s2_neg    = op_signed && in_s2[W-1];
    s1_abs    = s1_neg ? -in_s1 : in_s1;
    s2_abs    = s2_neg ? -in_s2 : in_s2;

    mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, a_q} : {(W+1){1'b0}});

    // Remainder stays below the divisor, so the shifted trial fits in W+1 bits.
    // A zero divisor makes every trial succeed: quotient all ones and the
    // remainder ends up equal to the dividend magnitude.
    div_trial   = acc_q[2*W-1:W-1];
    div_diff    = div_trial - {1'b0, a_q};
    div_ge      = (div_trial >= {1'b0, a_q});
    div_rem_nxt = div_ge ? div_diff[W-1:0] : div_trial[W-1:0];

    // Sign fix-up. Negating |s1| restores the raw dividend, which gives the
    // required HI for a signed divide by zero without a separate copy.
    prod_fix  = neg_quo_q ? -acc_q : acc_q;
    quo_fix   = neg_quo_q ? -acc_q[W-1:0] : acc_q[W-1:0];
    rem_fix   = neg_rem_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
  end

  // Next-state logic: accept in IDLE, iterate in CALC, commit in FIX.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    dbz_d     = dbz_q;
    done_d    = 1'b0;
    a_d       = a_q;
    acc_d     = acc_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    case (state_q)
      ST_IDLE: begin
        if (hi_wr_en) hi_d = wr_data;
        if (lo_wr_en) lo_d = wr_data;
        if (start && op_valid) begin
          state_d   = ST_CALC;
          cnt_d     = '0;
          is_div_d  = op_div;
          neg_quo_d = s1_neg ^ s2_neg;
          neg_rem_d = s1_neg;
          dbz_d     = op_div && (in_s2 == '0);
          a_d       = op_div ? s2_abs : s1_abs;
          acc_d     = {{W{1'b0}}, (op_div ? s1_abs : s2_abs)};
        end
      end
      ST_CALC: begin
        if (is_div_q) acc_d = {div_rem_nxt, acc_q[W-2:0], div_ge};
        else          acc_d = {mul_sum, acc_q[W-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = dbz_q ? {W{1'b1}} : quo_fix;
        end else begin
          hi_d = prod_fix[2*W-1:W];
          lo_d = prod_fix[W-1:0];
        end
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dbz_q     <= 1'b0;
      done_q    <= 1'b0;
      a_q       <= '0;
      acc_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      dbz_q     <= dbz_d;
      done_q    <= done_d;
      a_q       <= a_d;
      acc_q     <= acc_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_muldiv_unit
//
// Directed testbench for muldiv_unit with hand-computed expected values.
// Inputs change on the falling edge, outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_muldiv_unit;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [4:0]   alu_opcode;
  logic [W-1:0] in_s1;
  logic [W-1:0] in_s2;
  logic         hi_wr_en;
  logic         lo_wr_en;
  logic [W-1:0] wr_data;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int checks;
  int errors;
  int busyCycles;
  int donePulses;

  muldiv_unit #(.data_width(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .alu_opcode (alu_opcode),
    .in_s1      (in_s1),
    .in_s2      (in_s2),
    .hi_wr_en   (hi_wr_en),
    .lo_wr_en   (lo_wr_en),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero),
    .hi         (hi),
    .lo         (lo)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Present one start request for a single cycle, beginning on a falling edge.
  task automatic applyStimulus(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start      = 1'b1;
    alu_opcode = op;
    in_s1      = a;
    in_s2      = b;
    @(negedge clk);
    start      = 1'b0;
  endtask

  // Wait (bounded) for done; busyCycles counts sampled cycles with busy high,
  // including the one sample taken right after the accepting edge.
  task automatic waitDone(input string tag);
    bit seen;
    seen       = 1'b0;
    busyCycles = (busy === 1'b1) ? 1 : 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (busy === 1'b1) busyCycles++;
    end
    checkOutput({tag, "_done_seen"}, {63'b0, seen}, 64'd1);
  endtask

  // Full operation with result check.
  task automatic runOp(input string tag, input logic [4:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] expHi, input logic [W-1:0] expLo);
    applyStimulus(op, a, b);
    waitDone(tag);
    checkOutput({tag, "_hi"}, {32'b0, hi}, {32'b0, expHi});
    checkOutput({tag, "_lo"}, {32'b0, lo}, {32'b0, expLo});
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b0;
    start      = 1'b0;
    alu_opcode = 5'd0;
    in_s1      = '0;
    in_s2      = '0;
    hi_wr_en   = 1'b0;
    lo_wr_en   = 1'b0;
    wr_data    = '0;

    // Reset state
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_busy", {63'b0, busy}, 64'd0);
    checkOutput("rst_done", {63'b0, done}, 64'd0);
    checkOutput("rst_dbz",  {63'b0, div_by_zero}, 64'd0);
    checkOutput("rst_hi",   {32'b0, hi}, 64'd0);
    checkOutput("rst_lo",   {32'b0, lo}, 64'd0);

    // Invalid opcode with start is ignored
    applyStimulus(5'd5, 32'd1, 32'd1);
    checkOutput("badop_busy", {63'b0, busy}, 64'd0);

    // Signed multiply, with busy duration check
    runOp("mult_m3_m1", 5'd11, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h00000000, 32'h00000003);
    checkOutput("mult_busy_cycles", 64'(busyCycles), 64'd33);
    @(negedge clk);
    checkOutput("mult_done_pulse", {63'b0, done}, 64'd0);
    runOp("mult_m3_1", 5'd11, 32'hFFFFFFFD, 32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFD);

    // Unsigned multiply
    runOp("multu", 5'd12, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFC, 32'h00000003);
    checkOutput("multu_busy_cycles", 64'(busyCycles), 64'd33);

    // Divides, including the signed overflow case
    runOp("div_m8_3", 5'd13, 32'hFFFFFFF8, 32'd3, 32'hFFFFFFFE, 32'hFFFFFFFE);
    runOp("divu", 5'd14, 32'hFFFFFFF8, 32'd3, 32'h00000002, 32'h55555552);
    runOp("div_ovf", 5'd13, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    runOp("div_7_2", 5'd13, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);

    // Divide by zero and flag clearing
    runOp("div_by0", 5'd13, 32'd7, 32'd0, 32'h00000007, 32'hFFFFFFFF);
    checkOutput("div_by0_flag", {63'b0, div_by_zero}, 64'd1);
    checkOutput("div_by0_busy_cycles", 64'(busyCycles), 64'd33);
    runOp("div_neg_by0", 5'd13, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF);
    runOp("mult_2_2", 5'd11, 32'd2, 32'd2, 32'h00000000, 32'h00000004);
    checkOutput("mult_2_2_flag", {63'b0, div_by_zero}, 64'd0);

    // Start and MTHI while busy are ignored
    applyStimulus(5'd11, 32'd3, 32'd1);
    repeat (8) @(negedge clk);
    start      = 1'b1;
    alu_opcode = 5'd14;
    in_s1      = 32'd8;
    in_s2      = 32'd3;
    hi_wr_en   = 1'b1;
    wr_data    = 32'hDEADBEEF;
    @(negedge clk);
    start      = 1'b0;
    hi_wr_en   = 1'b0;
    donePulses = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done === 1'b1) donePulses++;
    end
    checkOutput("busy_ign_pulses", 64'(donePulses), 64'd1);
    checkOutput("busy_ign_hi", {32'b0, hi}, 64'h0);
    checkOutput("busy_ign_lo", {32'b0, lo}, 64'h3);

    // MTHI and MTLO together while idle
    hi_wr_en = 1'b1;
    lo_wr_en = 1'b1;
    wr_data  = 32'h12345678;
    @(negedge clk);
    hi_wr_en = 1'b0;
    lo_wr_en = 1'b0;
    checkOutput("mt_hi", {32'b0, hi}, 64'h12345678);
    checkOutput("mt_lo", {32'b0, lo}, 64'h12345678);
    checkOutput("mt_done", {63'b0, done}, 64'd0);
    checkOutput("mt_busy", {63'b0, busy}, 64'd0);

    // Reset in the middle of a divide
    applyStimulus(5'd13, 32'd100, 32'd7);
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy", {63'b0, busy}, 64'd0);
    checkOutput("midrst_done", {63'b0, done}, 64'd0);
    checkOutput("midrst_hi", {32'b0, hi}, 64'd0);
    checkOutput("midrst_lo", {32'b0, lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    donePulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) donePulses++;
    end
    checkOutput("midrst_no_done", 64'(donePulses), 64'd0);
    runOp("mult_5_5", 5'd11, 32'd5, 32'd5, 32'h00000000, 32'd25);

    // Start together with MTLO: write lands, result later overwrites LO
    @(negedge clk);
    start      = 1'b1;
    alu_opcode = 5'd12;
    in_s1      = 32'd6;
    in_s2      = 32'd7;
    lo_wr_en   = 1'b1;
    wr_data    = 32'hCAFEF00D;
    @(negedge clk);
    start      = 1'b0;
    lo_wr_en   = 1'b0;
    checkOutput("st_wr_lo", {32'b0, lo}, 64'hCAFEF00D);
    waitDone("st_wr");
    checkOutput("st_wr_res_lo", {32'b0, lo}, 64'd42);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Multi-cycle iterative multiply/divide engine that owns the architectural HI/LO registers of the MIPS datapath. It consumes the same MULT/MULTU/DIV/DIVU opcode encoding the combinational ALU uses, and replaces the ALU's single-cycle hi/result path with a start/busy/done handshake. Results are held in HI/LO for MFHI/MFLO reads. MTHI/MTLO writes are accepted when the unit is idle.

Parameters:
data_width, 32, operand width and HI/LO register width.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
alu_opcode  input  5  11=MULT, 12=MULTU, 13=DIV, 14=DIVU; other codes ignored
in_s1  input  data_width  multiplicand / dividend
in_s2  input  data_width  multiplier / divisor
hi_wr_en  input  1  MTHI write strobe
lo_wr_en  input  1  MTLO write strobe
wr_data  input  data_width  MTHI/MTLO data
busy  output  1  operation in progress
done  output  1  one-cycle pulse: HI/LO just updated by an operation
div_by_zero  output  1  sticky flag for the last operation; set when DIV/DIVU has in_s2==0
hi  output  data_width  HI register
lo  output  data_width  LO register

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy, done and div_by_zero = 0; hi and lo = 0; internal counters and accumulators cleared. Reset mid-operation aborts it: no done pulse, HI/LO = 0.
- States: IDLE, CALC, FIX.
- IDLE:
  - start=1 with a valid opcode at edge E0: latch the opcode, in_s1 and in_s2.
  - For signed ops, latch absolute values and record sign_q = s1[msb]^s2[msb] and sign_r = s1[msb].
  - Set busy=1 and iteration counter=0; go to CALC.
  - An invalid opcode with start is ignored and the unit stays in IDLE.
- CALC: one bit per cycle, exactly data_width cycles.
  - Multiply: shift-add into a 2*data_width accumulator.
  - Divide: restoring divide, one quotient bit per cycle.
  - At counter == data_width-1, go to FIX.
- FIX:
  - Apply sign correction: product negated if sign_q; quotient negated if sign_q; remainder negated if sign_r.
  - Write HI/LO (HI = product[2w-1:w] or remainder; LO = product[w-1:0] or quotient).
  - Set done=1 for the next cycle, busy=0, and go to IDLE.
- Latency: start accepted at E0; busy is high after E0 through edge E0+data_width+1; HI/LO are valid and done=1 after edge E0+data_width+1. Total data_width+1 cycles.
- Divide by zero: takes full latency. Result LO = all ones, HI = in_s1 as latched, regardless of signedness. div_by_zero=1 until the next accepted start.
- Signed overflow: -2^(w-1) / -1 gives LO = 0x80000000, HI = 0 (wrap, no flag).
- start while busy: ignored, with no queueing.
- MTHI/MTLO:
  - When not busy, hi_wr_en / lo_wr_en write wr_data into HI / LO at the edge.
  - Both strobes may be set in the same cycle.
  - Strobes while busy are ignored.
  - start together with a write strobe in IDLE: the write is applied and the operation starts. Its results later overwrite the written register.
- done pulses exactly one cycle per completed operation. hi and lo are register outputs, with no combinational path from the inputs.

Test Plan:
1. MULT in_s1=-3 (0xFFFFFFFD), in_s2=-1 -> after 33 cycles done=1, HI=0x00000000, LO=0x00000003. MULT -3 * 1 -> HI=0xFFFFFFFF, LO=0xFFFFFFFD.
2. MULTU 0xFFFFFFFD * 0xFFFFFFFF -> HI=0xFFFFFFFC, LO=0x00000003. busy high for exactly 33 cycles.
3. DIV -8/3 -> LO=0xFFFFFFFE, HI=0xFFFFFFFE. DIVU 0xFFFFFFF8/3 -> LO=0x55555552, HI=0x00000002. DIV 0x80000000 / -1 -> LO=0x80000000, HI=0.
4. DIV 7/0 -> LO=0xFFFFFFFF, HI=0x00000007, div_by_zero=1. The next MULT 2*2 clears the flag and gives LO=4.
5. Start MULT 3*1, then pulse start (DIVU 8/3) and hi_wr_en (wr_data=0xDEADBEEF) at cycle 10 -> both ignored; single done, HI=0, LO=3. After idle, hi_wr_en and lo_wr_en with 0x12345678 -> HI=LO=0x12345678, no done.
6. Start DIV, assert rst_n=0 at cycle 15 -> busy, done, HI and LO immediately 0. After release, no done pulse; a new MULT 5*5 gives LO=25.
